// File: rtl/alu_seq_if.sv
// alu_seq_if: bundles the request, response and ALU-drive signals of alu_seq.
//   req_*  : operation request channel (valid/ready), operands up to 16 bits
//   rsp_*  : result channel (valid/ready), 16-bit data plus flags word
//   alu_*  : registered operands/function to the combinational 8-bit ALU and
//            its combinational result/flags back
//   flags_q: architectural flags register read by branch logic
// Modports: slave = the sequencer (alu_seq), master = its environment.
interface alu_seq_if #(
  parameter int OP_W   = 3,
  parameter int FLAG_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic              req_wide;
  logic [15:0]       req_a;
  logic [15:0]       req_b;

  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [7:0]        alu_out;
  logic [FLAG_W-1:0] alu_flags;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_data;
  logic [FLAG_W-1:0] rsp_flags;
  logic [FLAG_W-1:0] flags_q;

  modport slave (
    input  req_valid, req_op, req_wide, req_a, req_b,
    input  alu_out, alu_flags, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_data, rsp_flags, flags_q
  );

  modport master (
    output req_valid, req_op, req_wide, req_a, req_b,
    output alu_out, alu_flags, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_data, rsp_flags, flags_q
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequencer that drives an external 8-bit combinational ALU.
//   Accepts 8-bit operations and 16-bit wide adds (wide honoured only for SUM),
//   runs one ALU pass per cycle (LO, HI, optional INC for the low carry),
//   returns result/flags over a valid/ready response channel and updates the
//   architectural flags register on the response handshake.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset, clears all state
//   bus   : alu_seq_if.slave (request, response, ALU drive, flags_q)
// Flags layout: {3'b0, parity, zero, overflow, negative, carry}.
module alu_seq #(
  parameter int OP_W   = 3,
  parameter int FLAG_W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam logic [OP_W-1:0] OP_ID  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUM = OP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_INC  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_a, w_a;
  logic [15:0]       r_b, w_b;
  logic              r_wide, w_wide;
  logic [7:0]        r_lo, w_lo;
  logic              r_c_lo, w_c_lo;
  logic              r_p_lo, w_p_lo;
  logic              r_c_hi, w_c_hi;
  logic [7:0]        r_alu_a, w_alu_a;
  logic [7:0]        r_alu_b, w_alu_b;
  logic [OP_W-1:0]   r_alu_op, w_alu_op;
  logic              r_rsp_valid, w_rsp_valid;
  logic [15:0]       r_rsp_data, w_rsp_data;
  logic [FLAG_W-1:0] r_rsp_flags, w_rsp_flags;
  logic [FLAG_W-1:0] r_flags_q, w_flags_q;

  // Flags of a wide add are rebuilt from the 16-bit result; parity follows the
  // low-byte pass and carry is whichever of the HI/INC passes carried out.
  function automatic logic [FLAG_W-1:0] wide_flags(
    input logic        a15,
    input logic        b15,
    input logic [15:0] r,
    input logic        carry,
    input logic        parity
  );
    logic [FLAG_W-1:0] f;
    f    = '0;
    f[0] = carry;
    f[1] = r[15];
    f[2] = (a15 == b15) && (r[15] != a15);
    f[3] = (r == 16'h0000);
    f[4] = parity;
    return f;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_a         = r_a;
    w_b         = r_b;
    w_wide      = r_wide;
    w_lo        = r_lo;
    w_c_lo      = r_c_lo;
    w_p_lo      = r_p_lo;
    w_c_hi      = r_c_hi;
    w_alu_a     = r_alu_a;
    w_alu_b     = r_alu_b;
    w_alu_op    = r_alu_op;
    w_rsp_valid = r_rsp_valid;
    w_rsp_data  = r_rsp_data;
    w_rsp_flags = r_rsp_flags;
    w_flags_q   = r_flags_q;

    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_a         = bus.req_a;
          w_b         = bus.req_b;
          w_wide      = bus.req_wide && (bus.req_op == OP_SUM);
          w_alu_a     = bus.req_a[7:0];
          w_alu_b     = bus.req_b[7:0];
          w_alu_op    = bus.req_op;
          w_state_nxt = S_LO;
        end
      end
      S_LO: begin
        w_lo   = bus.alu_out;
        w_c_lo = bus.alu_flags[0];
        w_p_lo = bus.alu_flags[4];
        if (!r_wide) begin
          w_rsp_data  = {8'h00, bus.alu_out};
          w_rsp_flags = bus.alu_flags;
          w_rsp_valid = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_alu_a     = r_a[15:8];
          w_alu_b     = r_b[15:8];
          w_alu_op    = OP_SUM;
          w_state_nxt = S_HI;
        end
      end
      S_HI: begin
        w_c_hi = bus.alu_flags[0];
        if (r_c_lo) begin
          // Fold the low-byte carry into the high byte with a +1 pass.
          w_alu_a     = bus.alu_out;
          w_alu_b     = 8'h01;
          w_alu_op    = OP_SUM;
          w_state_nxt = S_INC;
        end else begin
          w_rsp_data  = {bus.alu_out, r_lo};
          w_rsp_flags = wide_flags(r_a[15], r_b[15], {bus.alu_out, r_lo},
                                   bus.alu_flags[0], r_p_lo);
          w_rsp_valid = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_INC: begin
        w_rsp_data  = {bus.alu_out, r_lo};
        w_rsp_flags = wide_flags(r_a[15], r_b[15], {bus.alu_out, r_lo},
                                 r_c_hi | bus.alu_flags[0], r_p_lo);
        w_rsp_valid = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_flags_q   = r_rsp_flags;
          w_rsp_valid = 1'b0;
          w_alu_a     = 8'h00;
          w_alu_b     = 8'h00;
          w_alu_op    = OP_ID;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_wide      <= 1'b0;
      r_lo        <= '0;
      r_c_lo      <= 1'b0;
      r_p_lo      <= 1'b0;
      r_c_hi      <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= OP_ID;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_flags_q   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a;
      r_b         <= w_b;
      r_wide      <= w_wide;
      r_lo        <= w_lo;
      r_c_lo      <= w_c_lo;
      r_p_lo      <= w_p_lo;
      r_c_hi      <= w_c_hi;
      r_alu_a     <= w_alu_a;
      r_alu_b     <= w_alu_b;
      r_alu_op    <= w_alu_op;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_data  <= w_rsp_data;
      r_rsp_flags <= w_rsp_flags;
      r_flags_q   <= w_flags_q;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_flags = r_rsp_flags;
  assign bus.flags_q   = r_flags_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Initiator/sequencer that drives the 8-bit combinational ALU and captures its `out` and `flags`.
- Accepts 8-bit and 16-bit (wide add) operation requests over a valid/ready handshake.
- Wide adds run as multiple ALU passes, chaining the carry.
- Returns the result and flags over a valid/ready response channel, and holds the architectural flags register that the branch logic reads.

Parameters:
- OP_W, 3, width of the ALU function selector. It uses the `OP_*` encodings from constants.v.
- FLAG_W, 8, width of the flags word. Layout is {3'b0, parity, zero, overflow, negative, carry}.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset. Synchronous, active-low: sampled on the rising edge of clk; clears all state when low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- req_op  in  OP_W  ALU function.
- req_wide  in  1  16-bit operation. Honoured only when req_op == `OP_SUM`.
- req_a  in  16  operand A. Only [7:0] is used when the operation is not wide.
- req_b  in  16  operand B. Only [7:0] is used when the operation is not wide.
- alu_a  out  8  registered ALU operand a.
- alu_b  out  8  registered ALU operand b.
- alu_op  out  OP_W  registered ALU function.
- alu_out  in  8  ALU result; combinational from alu_a, alu_b and alu_op.
- alu_flags  in  FLAG_W  ALU flags; combinational.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  16  result. Bits [15:8] are 0 for non-wide operations.
- rsp_flags  out  FLAG_W  flags of this operation.
- flags_q  out  FLAG_W  architectural flags register.

Behaviour:
- Reset (rst_n low at an edge):
  - state = IDLE; rsp_valid = 0; rsp_data = 0; rsp_flags = 0; flags_q = 0.
  - alu_a = 0, alu_b = 0, alu_op = `OP_ID`.
  - Reset at any point, including mid-wide-operation, discards the transaction with no response and no flags_q update.
- States: IDLE, LO, HI, INC, RESP. Exactly one transaction is in flight.
- ALU drive:
  - On entering LO, HI or INC, the block registers alu_a, alu_b and alu_op for that pass.
  - alu_out and alu_flags are captured at the end of that cycle.
  - On return to IDLE, alu_a and alu_b are set to 0 and alu_op to `OP_ID`.
- IDLE:
  - req_ready = 1.
  - On accept, latch the operands. wide_eff = req_wide & (req_op == `OP_SUM`). Drive the low-byte pass (a[7:0], b[7:0], op) and go to LO.
- LO:
  - Capture lo = alu_out, c_lo = alu_flags[0], p_lo = alu_flags[4].
  - If !wide_eff: rsp_data = {8'h00, lo}, rsp_flags = alu_flags, go to RESP.
  - Otherwise drive (a[15:8], b[15:8], `OP_SUM`) and go to HI.
- HI:
  - Capture hi = alu_out, c_hi = alu_flags[0].
  - If c_lo: drive (alu_out, 8'h01, `OP_SUM`) and go to INC.
  - Otherwise finish the wide operation with the captured values and go to RESP.
- INC:
  - Capture hi = alu_out and c_inc = alu_flags[0], finish the wide operation, go to RESP.
- Wide flags, computed locally from the 16-bit result r:
  - carry = c_hi | c_inc.
  - zero = (r == 0).
  - negative = r[15].
  - overflow = (a[15] == b[15]) & (r[15] != a[15]).
  - parity = p_lo.
- RESP:
  - rsp_valid = 1. rsp_data and rsp_flags stay stable until rsp_valid & rsp_ready.
  - On that handshake edge: flags_q <= rsp_flags, rsp_valid <= 0, go to IDLE.
  - req_ready = 0 throughout RESP.
- Latency, counted in edges after the accept edge until rsp_valid is high:
  - 1 for non-wide operations.
  - 2 for wide without low carry.
  - 3 for wide with low carry.
- Next-accept timing: the earliest next accept is the edge after the response handshake, because req_ready is only high in IDLE.
- Arithmetic: all captured values are taken modulo 2^8 per pass; 16-bit results wrap modulo 2^16.

Test Plan:
- Non-wide `OP_SUM`, a=0x007F, b=0x0001 -> rsp_valid 1 edge after accept; rsp_data=0x0080; rsp_flags=0x06; flags_q=0x06 after the handshake.
- Wide `OP_SUM`, 0x00FF + 0x0001 -> passes LO, HI, INC; rsp_valid 3 edges after accept; rsp_data=0x0100; rsp_flags=0x10.
- Wide `OP_SUM`, 0xFFFF + 0x0001 -> rsp_data=0x0000, rsp_flags=0x19. Then 0x7FFF + 0x0001 -> rsp_data=0x8000, rsp_flags=0x16.
- Wide `OP_SUM`, 0x1234 + 0x0101 (no low carry) -> INC skipped; rsp_valid 2 edges after accept; rsp_data=0x1335.
- `OP_AND` with req_wide=1, a=0xF0F0, b=0x0FFF -> treated as non-wide; rsp_data=0x00F0; latency 1.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_flags stable; req_ready=0; flags_q unchanged until the handshake. Separately, drop rst_n during HI -> next edge IDLE, req_ready=1, rsp_valid=0, flags_q=0, alu_op=`OP_ID`.
